// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// control sequencer with one-hot phase enables, stall / memory-skip / halt
// handling and saturating cycle and retired-instruction counters.
// Optional watchdog compiled in with `define CYCLE_LIMIT_EN; it forces
// HALTED and sets the sticky timeout flag when cycle_count reaches MAX_CYCLES.
module cpu_phase_sequencer #(
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 skip_mem,
  input  logic                 halt,
  output logic [4:0]           phase,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALTED    = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic                 active;
  logic                 wb_exit;
  logic                 wd_hit;
  logic [CNT_WIDTH-1:0] cycle_inc;
  logic [CNT_WIDTH-1:0] instr_inc;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign active    = (state != IDLE) && (state != HALTED);
  assign wb_exit   = (state == WRITEBACK) && !stall;
  assign cycle_inc = sat_inc(cycle_count);
  assign instr_inc = sat_inc(instr_count);

`ifdef CYCLE_LIMIT_EN
  localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(MAX_CYCLES);

  // Watchdog fires on the active edge at which cycle_count reaches the limit.
  assign wd_hit = active && (cycle_inc == WD_LIMIT);

  // Sticky timeout flag; only a fresh start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (!active && start) begin
      timeout <= 1'b0;
    end else if (wd_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state selection; stall freezes every active phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALTED: if (start) state_nxt = FETCH;
      FETCH:        if (!stall) state_nxt = DECODE;
      DECODE:       if (!stall) state_nxt = EXECUTE;
      EXECUTE:      if (!stall) state_nxt = skip_mem ? WRITEBACK : MEMORY;
      MEMORY:       if (!stall) state_nxt = WRITEBACK;
      WRITEBACK:    if (!stall) state_nxt = halt ? HALTED : FETCH;
      default:      state_nxt = IDLE;
    endcase
    if (wd_hit) state_nxt = HALTED;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counters: cleared by a start from IDLE/HALTED, advanced while active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (!active && start) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (active) begin
      cycle_count <= cycle_inc;
      if (wb_exit) instr_count <= instr_inc;
    end
  end

  // Output decode straight from the registered state.
  always_comb begin
    phase   = 5'b00000;
    running = active;
    done    = (state == HALTED);
    case (state)
      FETCH:     phase = 5'b00001;
      DECODE:    phase = 5'b00010;
      EXECUTE:   phase = 5'b00100;
      MEMORY:    phase = 5'b01000;
      WRITEBACK: phase = 5'b10000;
      default:   phase = 5'b00000;
    endcase
  end

endmodule
